// File: rtl/rom_load_pkg.sv
// Shared types and defaults for the ROM download controller.
// Exports: rl_state_t, ROM_IDX_DEF, CFG_IDX_DEF.
package rom_load_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SETTLE,
    RUN
  } rl_state_t;

  localparam logic [7:0] ROM_IDX_DEF = 8'd0;
  localparam logic [7:0] CFG_IDX_DEF = 8'd1;

endpackage

// File: rtl/rom_load_settle_tmr.sv
// Post-download settle timer: clear / count / terminal count.
// Ports: clk, rst, clr, en in; tc out (count == CYC-1).
module rom_load_settle_tmr #(
  parameter int unsigned CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned W = $clog2(CYC);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc = (cnt == W'(CYC - 1));

endmodule

// File: rtl/rom_load_ctrl.sv
// Routes the ioctl download stream to the core ROM port, latches the
// title number, and holds the core in reset through load + settle.
// In:  clk_sys, RESET, ioctl_download/wr/addr/dout/index, user_reset.
// Out: core_reset, rom_wr/addr/data, tno, load_done, load_err, csum.
// Build option ROM_LOAD_CSUM_EN enables the checksum of accepted bytes.
module rom_load_ctrl
  import rom_load_pkg::*;
#(
  parameter logic [7:0]  ROM_IDX    = ROM_IDX_DEF,
  parameter logic [7:0]  CFG_IDX    = CFG_IDX_DEF,
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned ROM_SIZE   = 'h1C000,
  parameter int unsigned SETTLE_CYC = 1024
) (
  input  logic              clk_sys,
  input  logic              RESET,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [7:0]        ioctl_index,
  input  logic              user_reset,
  output logic              core_reset,
  output logic              rom_wr,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [7:0]        rom_data,
  output logic [3:0]        tno,
  output logic              load_done,
  output logic              load_err,
  output logic [15:0]       csum
);

  rl_state_t state;

  logic dl_q;
  logic rise;
  logic rom_hit;
  logic in_rng;
  logic accept;
  logic oor;
  logic cfg_wr;
  logic tc;

  // dl_q resets high so a download already active when RESET
  // drops is not mistaken for a new load start.
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      dl_q <= 1'b1;
    end else begin
      dl_q <= ioctl_download;
    end
  end

  assign rise    = ioctl_download & ~dl_q;
  assign rom_hit = ioctl_wr & (ioctl_index == ROM_IDX);
  assign in_rng  = (ioctl_addr < 25'(ROM_SIZE));
  assign accept  = rom_hit & in_rng;
  assign oor     = rom_hit & ~in_rng;
  assign cfg_wr  = ioctl_wr & (ioctl_index == CFG_IDX);

  rom_load_settle_tmr #(
    .CYC (SETTLE_CYC)
  ) u_tmr (
    .clk (clk_sys),
    .rst (RESET),
    .clr (state != SETTLE),
    .en  (state == SETTLE),
    .tc  (tc)
  );

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      core_reset <= 1'b1;
      load_done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rise) state <= LOAD;
        end
        LOAD: begin
          if (!ioctl_download) state <= SETTLE;
        end
        SETTLE: begin
          if (rise) begin
            state <= LOAD;
          end else if (tc) begin
            state      <= RUN;
            core_reset <= user_reset;
            load_done  <= 1'b1;
          end
        end
        RUN: begin
          if (rise) begin
            state      <= LOAD;
            core_reset <= 1'b1;
            load_done  <= 1'b0;
          end else begin
            core_reset <= user_reset;
          end
        end
        default: begin
          state      <= IDLE;
          core_reset <= 1'b1;
          load_done  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      rom_wr   <= 1'b0;
      rom_addr <= '0;
      rom_data <= '0;
      tno      <= '0;
      load_err <= 1'b0;
    end else begin
      rom_wr <= accept;
      if (accept) begin
        rom_addr <= ioctl_addr[ADDR_W-1:0];
        rom_data <= ioctl_dout;
      end
      if (cfg_wr) tno <= ioctl_dout[3:0];
      load_err <= (rise ? 1'b0 : load_err) | oor;
    end
  end

`ifdef ROM_LOAD_CSUM_EN
  logic [15:0] csum_q;

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      csum_q <= '0;
    end else begin
      csum_q <= (rise ? 16'h0 : csum_q) +
                (accept ? {8'h0, ioctl_dout} : 16'h0);
    end
  end

  assign csum = csum_q;
`else
  assign csum = 16'h0000;
`endif

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Directed bench for rom_load_ctrl.
// Drives download sequences and checks outputs against fixed values.
module tb_rom_load_ctrl;

  localparam int SCYC = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dl = 1'b0;
  logic        wr = 1'b0;
  logic [24:0] addr = '0;
  logic [7:0]  dout = '0;
  logic [7:0]  idx = '0;
  logic        ures = 1'b0;
  logic        core_reset;
  logic        rom_wr;
  logic [16:0] rom_addr;
  logic [7:0]  rom_data;
  logic [3:0]  tno;
  logic        load_done;
  logic        load_err;
  logic [15:0] csum;

  int n_cmp = 0;
  int n_bad = 0;

  rom_load_ctrl dut (
    .clk_sys        (clk),
    .RESET          (rst),
    .ioctl_download (dl),
    .ioctl_wr       (wr),
    .ioctl_addr     (addr),
    .ioctl_dout     (dout),
    .ioctl_index    (idx),
    .user_reset     (ures),
    .core_reset     (core_reset),
    .rom_wr         (rom_wr),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .tno            (tno),
    .load_done      (load_done),
    .load_err       (load_err),
    .csum           (csum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [7:0] i,
                         input logic [24:0] a,
                         input logic [7:0] d);
    idx  = i;
    addr = a;
    dout = d;
    wr   = 1'b1;
    cyc();
    wr   = 1'b0;
  endtask

  // Drop download and count edges until core_reset falls.
  task automatic settle(output int n);
    n  = 0;
    dl = 1'b0;
    while (core_reset && n < 3000) begin
      cyc();
      n++;
    end
  endtask

  int n;
  bit seen;

  initial begin
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;

    // 1: idle after reset
    chk("rst_core_reset", core_reset, 1);
    chk("rst_csum", csum, 0);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (rom_wr) seen = 1;
    end
    chk("idle_core_reset", core_reset, 1);
    chk("idle_load_done", load_done, 0);
    chk("idle_tno", tno, 0);
    chk("idle_no_wr", seen, 0);

    // 2: four-byte load
    dl = 1'b1;
    cyc();
    wr_byte(8'd0, 25'd0, 8'hA5);
    chk("b0_wr", rom_wr, 1);
    chk("b0_addr", rom_addr, 0);
    chk("b0_data", rom_data, 8'hA5);
    cyc();
    chk("b0_wr_clr", rom_wr, 0);
    chk("b0_hold", rom_data, 8'hA5);
    wr_byte(8'd0, 25'd1, 8'h5A);
    chk("b1_wr", rom_wr, 1);
    chk("b1_addr", rom_addr, 1);
    chk("b1_data", rom_data, 8'h5A);
    wr_byte(8'd0, 25'd2, 8'hFF);
    chk("b2_wr", rom_wr, 1);
    chk("b2_addr", rom_addr, 2);
    chk("b2_data", rom_data, 8'hFF);
    wr_byte(8'd0, 25'd3, 8'h01);
    chk("b3_wr", rom_wr, 1);
    chk("b3_addr", rom_addr, 3);
    chk("b3_data", rom_data, 8'h01);
    cyc();
    chk("load_core_reset", core_reset, 1);
    settle(n);
    chk("settle_len", n, SCYC + 1);
    chk("run_done", load_done, 1);
`ifdef ROM_LOAD_CSUM_EN
    chk("csum4", csum, 16'h01FF);
`else
    chk("csum_off", csum, 0);
`endif

    // user_reset passthrough in RUN
    ures = 1'b1;
    cyc();
    chk("ures_hi", core_reset, 1);
    ures = 1'b0;
    cyc();
    chk("ures_lo", core_reset, 0);

    // 3: config index, last write wins, survives a load
    wr_byte(8'd1, 25'd0, 8'h23);
    chk("tno_3", tno, 3);
    wr_byte(8'd1, 25'd0, 8'h05);
    chk("tno_5", tno, 5);
    wr_byte(8'd7, 25'd9, 8'h66);
    chk("unk_no_wr", rom_wr, 0);
    chk("unk_no_err", load_err, 0);
    dl = 1'b1;
    cyc();
    chk("reload_done_lo", load_done, 0);
    chk("reload_core_rst", core_reset, 1);
    wr_byte(8'd0, 25'd5, 8'h10);
    settle(n);
    chk("settle_len2", n, SCYC + 1);
    chk("tno_keep", tno, 5);
`ifdef ROM_LOAD_CSUM_EN
    chk("csum_new", csum, 16'h0010);
`endif

    // 4: ROM_SIZE boundary
    dl = 1'b1;
    cyc();
    wr_byte(8'd0, 25'h1BFFF, 8'h77);
    chk("last_wr", rom_wr, 1);
    chk("last_addr", rom_addr, 17'h1BFFF);
    chk("last_err", load_err, 0);
    wr_byte(8'd0, 25'h1C000, 8'h88);
    chk("oor_wr", rom_wr, 0);
    chk("oor_err", load_err, 1);
    chk("oor_data", rom_data, 8'h77);
    dl = 1'b0;
    cyc();
    cyc();
    chk("err_sticky", load_err, 1);
    dl = 1'b1;
    cyc();
    chk("err_clr", load_err, 0);
`ifdef ROM_LOAD_CSUM_EN
    chk("csum_clr", csum, 0);
`endif

    // 5: download re-asserted mid-settle
    dl = 1'b0;
    for (int i = 0; i < 501; i++) cyc();
    dl = 1'b1;
    cyc();
    chk("resume_core_rst", core_reset, 1);
    chk("resume_done", load_done, 0);
    for (int i = 0; i < 600; i++) cyc();
    chk("resume_hold", core_reset, 1);
    settle(n);
    chk("settle_len3", n, SCYC + 1);

    // 6: async reset mid-load
    dl = 1'b1;
    cyc();
    wr_byte(8'd0, 25'd8, 8'h3C);
    wr_byte(8'd0, 25'd9, 8'hC3);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_core_reset", core_reset, 1);
    chk("ar_rom_wr", rom_wr, 0);
    chk("ar_rom_addr", rom_addr, 0);
    chk("ar_rom_data", rom_data, 0);
    chk("ar_tno", tno, 0);
    chk("ar_done", load_done, 0);
    chk("ar_err", load_err, 0);
    chk("ar_csum", csum, 0);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    dl = 1'b0;
    for (int i = 0; i < 1100; i++) cyc();
    chk("ar_idle_core", core_reset, 1);
    chk("ar_idle_done", load_done, 0);
    dl = 1'b1;
    cyc();
    cyc();
    settle(n);
    chk("settle_len4", n, SCYC + 1);
    chk("final_done", load_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
